// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//  Shared definitions for the serial adder slice:
//   - state_t     : FSM state encoding (IDLE / RUN / DONE)
//   - clog2_min1  : ceil(log2(n)) clamped to a minimum of 1, used to size the
//                   step counter so a single-step configuration still gets a
//                   legal 1-bit counter.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// serial_adder_full_adder
//  One-bit combinational full adder built from two half-adder stages.
//  Ports:
//   a, b  in   addend bits
//   ci    in   carry in
//   s     out  sum bit
//   co    out  carry out
// -----------------------------------------------------------------------------
module serial_adder_full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic s1;
   logic c1;
   logic c2;

   // First half adder: a + b
   assign s1 = a ^ b;
   assign c1 = a & b;

   // Second half adder: partial sum + carry in
   assign s  = s1 ^ ci;
   assign c2 = s1 & ci;

   assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//  Multi-cycle adder: computes a + b + cin over WIDTH bits, DIGIT bits per
//  clock, through a registered carry. STEPS = WIDTH/DIGIT cycles per add.
//  Parameters:
//   WIDTH  operand/sum width (>= 2)
//   DIGIT  bits added per cycle; must divide WIDTH evenly
//  Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operands valid
//   in_ready   out  block can accept operands (IDLE only)
//   a, b       in   operands, sampled only at the accept edge
//   cin        in   carry-in, sampled only at the accept edge
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts result
//   sum        out  (a+b+cin) mod 2^WIDTH
//   cout       out  unsigned carry-out
//   ovf        out  two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = clog2_min1(STEPS);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q;

   logic [DIGIT:0]   carry;
   logic [DIGIT-1:0] chain_sum;
   logic             last_step;

   // Ripple chain over the DIGIT low bits of the operand shift registers.
   assign carry[0] = carry_q;

   for (genvar i = 0; i < DIGIT; i++) begin : g_chain
      serial_adder_full_adder u_fa (
         .a  (a_q[i]),
         .b  (b_q[i]),
         .ci (carry[i]),
         .s  (chain_sum[i]),
         .co (carry[i+1])
      );
   end

   // New digit enters at the MSB end; after STEPS shifts the LSB digit has
   // travelled down to bit 0.
   assign acc_d     = (acc_q >> DIGIT) | (WIDTH'(chain_sum) << (WIDTH - DIGIT));
   assign last_step = (state_q == RUN) && (cnt_q == CW'(STEPS - 1));

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (last_step) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               acc_q   <= acc_d;
               carry_q <= carry[DIGIT];
               cnt_q   <= cnt_q + CW'(1);
               if (last_step) begin
                  // Output registers only move here, so they hold steady
                  // through DONE and the following idle/run period.
                  sum_q  <= acc_d;
                  cout_q <= carry[DIGIT];
                  // Overflow: carry into the MSB stage xor carry out of it.
                  ovf_q  <= carry[DIGIT] ^ carry[DIGIT-1];
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//  Two instances: WIDTH=8/DIGIT=1 (8 steps) and WIDTH=16/DIGIT=4 (4 steps).
//  Shared stimulus bus; sel chooses which instance is driven and observed.
//  Expected results come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_adder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sel;        // 0: 8-bit instance, 1: 16-bit instance
   logic        iv;
   logic [15:0] a_drv, b_drv;
   logic        cin_drv;
   logic        out_ready;

   logic        in_ready8, out_valid8, cout8, ovf8;
   logic [7:0]  sum8;
   logic        in_ready16, out_valid16, cout16, ovf16;
   logic [15:0] sum16;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv & ~sel),
      .in_ready  (in_ready8),
      .a         (a_drv[7:0]),
      .b         (b_drv[7:0]),
      .cin       (cin_drv),
      .out_valid (out_valid8),
      .out_ready (out_ready & ~sel),
      .sum       (sum8),
      .cout      (cout8),
      .ovf       (ovf8)
   );

   serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv & sel),
      .in_ready  (in_ready16),
      .a         (a_drv),
      .b         (b_drv),
      .cin       (cin_drv),
      .out_valid (out_valid16),
      .out_ready (out_ready & sel),
      .sum       (sum16),
      .cout      (cout16),
      .ovf       (ovf16)
   );

   logic        in_ready_o, out_valid_o, cout_o, ovf_o;
   logic [15:0] sum_o;
   assign in_ready_o  = sel ? in_ready16  : in_ready8;
   assign out_valid_o = sel ? out_valid16 : out_valid8;
   assign cout_o      = sel ? cout16      : cout8;
   assign ovf_o       = sel ? ovf16       : ovf8;
   assign sum_o       = sel ? sum16       : {8'h00, sum8};

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: {ovf, cout, sum} for a w-bit add, from plain arithmetic.
   function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic c);
      logic [16:0] t;
      logic [15:0] s;
      logic        co, sa, sb, ss;
      if (w == 8) begin
         t  = {9'd0, a[7:0]} + {9'd0, b[7:0]} + {16'd0, c};
         s  = {8'h00, t[7:0]};
         co = t[8];
      end else begin
         t  = {1'b0, a} + {1'b0, b} + {16'd0, c};
         s  = t[15:0];
         co = t[16];
      end
      sa = a[w-1];
      sb = b[w-1];
      ss = s[w-1];
      // Signed overflow: like-signed operands giving a differently signed result.
      return {(sa == sb) && (ss != sa), co, s};
   endfunction

   // Accept one operation, wait for the result and check it. Leaves the DUT in DONE.
   task automatic op(input logic wide, input logic [15:0] a, input logic [15:0] b, input logic c,
                     input string tag, output int acc_cyc);
      int          steps;
      int          lat;
      logic [17:0] e;
      steps   = wide ? 4 : 8;
      sel     = wide;
      a_drv   = a;
      b_drv   = b;
      cin_drv = c;
      iv      = 1'b1;
      check({tag, " in_ready"}, {31'd0, in_ready_o}, 32'd1);
      tick();
      acc_cyc = cyc;
      iv      = 1'b0;
      check({tag, " busy"}, {31'd0, in_ready_o}, 32'd0);
      lat = 0;
      while (out_valid_o !== 1'b1 && lat < 64) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, steps);
      e = model(wide ? 16 : 8, a, b, c);
      check({tag, " sum"},  {16'd0, sum_o},  {16'd0, e[15:0]});
      check({tag, " cout"}, {31'd0, cout_o}, {31'd0, e[16]});
      check({tag, " ovf"},  {31'd0, ovf_o},  {31'd0, e[17]});
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " out_valid drop"}, {31'd0, out_valid_o}, 32'd0);
      check({tag, " in_ready back"},  {31'd0, in_ready_o},  32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, prev;
      logic [15:0] ra, rb;
      logic        rc;

      rst = 1'b1; sel = 1'b0; iv = 1'b0; out_ready = 1'b0;
      a_drv = '0; b_drv = '0; cin_drv = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state of both instances
      check("rst8 in_ready",   {31'd0, in_ready8},   32'd1);
      check("rst8 out_valid",  {31'd0, out_valid8},  32'd0);
      check("rst8 sum",        {24'd0, sum8},        32'd0);
      check("rst8 cout/ovf",   {30'd0, cout8, ovf8}, 32'd0);
      check("rst16 in_ready",  {31'd0, in_ready16},  32'd1);
      check("rst16 out_valid", {31'd0, out_valid16}, 32'd0);
      check("rst16 sum",       {16'd0, sum16},       32'd0);

      // Directed 8-bit cases
      op(1'b0, 16'h0000, 16'h0000, 1'b0, "zero", acc);
      release_result("zero");
      op(1'b0, 16'h00FF, 16'h0001, 1'b0, "ff+1", acc);
      release_result("ff+1");
      op(1'b0, 16'h007F, 16'h0001, 1'b0, "7f+1", acc);
      release_result("7f+1");

      // Reset landing on the fourth RUN edge discards the operation
      sel = 1'b0; a_drv = 16'h0012; b_drv = 16'h0034; cin_drv = 1'b0; iv = 1'b1;
      tick();
      iv = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrun rst in_ready",  {31'd0, in_ready8},   32'd1);
      check("midrun rst out_valid", {31'd0, out_valid8},  32'd0);
      check("midrun rst sum",       {24'd0, sum8},        32'd0);
      check("midrun rst cout/ovf",  {30'd0, cout8, ovf8}, 32'd0);
      op(1'b0, 16'h0010, 16'h0020, 1'b0, "after rst", acc);
      release_result("after rst");

      // Backpressure: DONE holds, a second in_valid is ignored
      op(1'b0, 16'h00A5, 16'h005A, 1'b1, "a5+5a", acc);
      for (int i = 0; i < 5; i++) begin
         iv = 1'b1; a_drv = 16'h0011; b_drv = 16'h0022; cin_drv = 1'b0;
         tick();
         check("hold out_valid", {31'd0, out_valid_o}, 32'd1);
         check("hold in_ready",  {31'd0, in_ready_o},  32'd0);
         check("hold sum",       {16'd0, sum_o},       32'd0);
         check("hold cout",      {31'd0, cout_o},      32'd1);
      end
      iv = 1'b0;
      release_result("hold");
      tick(); tick();
      check("no ghost op", {31'd0, out_valid_o}, 32'd0);
      check("ghost sum",   {16'd0, sum_o},       32'd0);

      // 16-bit, 4 bits per step
      op(1'b1, 16'h8000, 16'h8000, 1'b0, "w16 8000+8000", acc);
      release_result("w16");
      op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "w16 ffff+ffff+1", acc);
      release_result("w16 max");
      op(1'b1, 16'h7FFF, 16'h0000, 1'b1, "w16 7fff+1", acc);
      release_result("w16 ovf");

      // Back-to-back random stream, out_ready held high
      out_ready = 1'b1;
      prev = 0;
      for (int i = 0; i < 100; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
         op(1'b0, ra, rb, rc, "rand8", acc);
         if (i > 0) check("rand8 interval", acc - prev, 10);
         prev = acc;
         tick();
      end
      for (int i = 0; i < 30; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
         op(1'b1, ra, rb, rc, "rand16", acc);
         if (i > 0) check("rand16 interval", acc - prev, 6);
         prev = acc;
         tick();
      end
      out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
